// File: rtl/peripheral_spram_ahb4_slave.sv
// rtl/peripheral_spram_ahb4_slave.sv - AHB4-Lite slave front end for a byte-write single-port RAM
module peripheral_spram_ahb4_slave #(
  parameter int DEPTH = 256,
  parameter int PLEN  = 32,
  parameter int XLEN  = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic            HSEL,
  input  logic [PLEN-1:0] HADDR,
  input  logic [XLEN-1:0] HWDATA,
  output logic [XLEN-1:0] HRDATA,
  input  logic            HWRITE,
  input  logic [2:0]      HSIZE,
  input  logic [2:0]      HBURST,
  input  logic [3:0]      HPROT,
  input  logic [1:0]      HTRANS,
  input  logic            HMASTLOCK,
  input  logic            HREADY,
  output logic            HREADYOUT,
  output logic            HRESP,
  output logic [3:0]      ram_we,
  output logic [XLEN-1:0] ram_din,
  output logic [AW-1:0]   ram_waddr,
  output logic [AW-1:0]   ram_raddr,
  input  logic [XLEN-1:0] ram_dout
);

  typedef enum logic [1:0] {ST_OK, ST_ERR1, ST_ERR2} state_t;

  state_t          state;
  logic            hreadyout_q, hresp_q;
  logic            accept, aligned, legal;
  logic            rd_accept, wr_accept, err_accept;
  logic [3:0]      be;
  logic [AW-1:0]   word_addr;
  logic            wr_pend, rd_pend;
  logic [AW-1:0]   wr_addr, raddr_q;
  logic [3:0]      wr_be, byp_be;
  logic [XLEN-1:0] byp_data;
  logic            unused_ok;

  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  assign word_addr = HADDR[AW+1:2];
  assign accept    = HSEL & HREADY & HTRANS[1] & (state != ST_ERR1);

  always_comb begin
    aligned = 1'b1;
    be      = 4'b1111;
    case (HSIZE)
      3'd0: be = 4'b0001 << HADDR[1:0];
      3'd1: begin
        be      = 4'b0011 << HADDR[1:0];
        aligned = ~HADDR[0];
      end
      default: aligned = (HADDR[1:0] == 2'b00);
    endcase
  end

  assign legal      = (HSIZE <= 3'd2) && aligned && (HADDR[PLEN-1:AW+2] == '0);
  assign rd_accept  = accept & legal & ~HWRITE;
  assign wr_accept  = accept & legal & HWRITE;
  assign err_accept = accept & ~legal;

  // RAM side: write uses registered address-phase info, read address goes out combinationally
  assign ram_we    = wr_pend ? wr_be : 4'b0000;
  assign ram_waddr = wr_addr;
  assign ram_din   = HWDATA;
  assign ram_raddr = rd_accept ? word_addr : raddr_q;

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

  // RAM returns the pre-write word on a same-cycle collision, so patch in the written lanes
  always_comb begin
    HRDATA = '0;
    if (rd_pend) begin
      for (int i = 0; i < 4; i++) begin
        HRDATA[8*i +: 8] = byp_be[i] ? byp_data[8*i +: 8] : ram_dout[8*i +: 8];
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= ST_OK;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      wr_pend     <= 1'b0;
      rd_pend     <= 1'b0;
      wr_addr     <= '0;
      wr_be       <= '0;
      raddr_q     <= '0;
      byp_be      <= '0;
      byp_data    <= '0;
    end else begin
      wr_pend <= wr_accept;
      rd_pend <= rd_accept;
      if (wr_accept) begin
        wr_addr <= word_addr;
        wr_be   <= be;
      end
      if (rd_accept) begin
        raddr_q <= word_addr;
        if (wr_pend && (wr_addr == word_addr)) begin
          byp_be   <= wr_be;
          byp_data <= HWDATA;
        end else begin
          byp_be   <= 4'b0000;
        end
      end

      case (state)
        ST_OK: begin
          if (err_accept) begin
            state       <= ST_ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= 1'b1;
          end
        end
        ST_ERR1: begin
          state       <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        ST_ERR2: begin
          if (err_accept) begin
            state       <= ST_ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= 1'b1;
          end else begin
            state       <= ST_OK;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
        default: begin
          state       <= ST_OK;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_spram_ahb4_slave.sv
// tb/tb_peripheral_spram_ahb4_slave.sv - directed bench for peripheral_spram_ahb4_slave
module tb_peripheral_spram_ahb4_slave;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [3:0]  ram_we;
  logic [31:0] ram_din;
  logic [AW-1:0] ram_waddr;
  logic [AW-1:0] ram_raddr;
  logic [31:0] ram_dout = 32'h0;

  logic [31:0] mem [DEPTH];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 HCLK = ~HCLK;

  // single-slave bus: HREADY follows the slave
  assign HREADY = HREADYOUT;

  peripheral_spram_ahb4_slave #(.DEPTH(DEPTH), .PLEN(32), .XLEN(32), .AW(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .ram_we(ram_we), .ram_din(ram_din), .ram_waddr(ram_waddr),
    .ram_raddr(ram_raddr), .ram_dout(ram_dout)
  );

  // RAM core: byte writes, registered read returning the pre-write contents
  always @(posedge HCLK) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we[i]) mem[ram_waddr][8*i +: 8] <= ram_din[8*i +: 8];
    end
    ram_dout <= mem[ram_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // one bus cycle: drive address phase + HWDATA of the current data phase, settle before sampling
  task automatic cyc(input logic sel, input logic [1:0] trans, input logic wr,
                     input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge HCLK);
    HSEL   = sel;
    HTRANS = trans;
    HWRITE = wr;
    HSIZE  = size;
    HADDR  = addr;
    HWDATA = wdata;
    #1;
  endtask

  task automatic idle(input logic [31:0] wdata);
    cyc(1'b0, T_IDLE, 1'b0, 3'd2, 32'h0, wdata);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = 32'h0; HWDATA = 32'h0; HWRITE = 1'b0;
    HSIZE = 3'd2; HBURST = 3'd0; HPROT = 4'h3; HTRANS = T_IDLE; HMASTLOCK = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_hreadyout", {31'b0, HREADYOUT}, 32'h1);
    chk("rst_hresp",     {31'b0, HRESP},     32'h0);
    chk("rst_hrdata",    HRDATA,             32'h0);
    chk("rst_ram_we",    {28'b0, ram_we},    32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // unselected and IDLE transfers must not touch the RAM
    cyc(1'b0, T_NONSEQ, 1'b1, 3'd2, 32'h10, 32'h0);
    cyc(1'b1, T_IDLE,   1'b1, 3'd2, 32'h10, 32'h0);
    chk("nosel_we", {28'b0, ram_we}, 32'h0);
    idle(32'h0);
    chk("idle_we",   {28'b0, ram_we}, 32'h0);
    chk("idle_resp", {30'b0, HREADYOUT, HRESP}, 32'h2);

    // word write then immediate read of the same word
    cyc(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h10, 32'h0);
    cyc(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h10, 32'hDEADBEEF);
    chk("w1_we",    {28'b0, ram_we}, 32'hF);
    chk("w1_waddr", {24'b0, ram_waddr}, 32'h4);
    chk("w1_din",   ram_din, 32'hDEADBEEF);
    chk("w1_raddr", {24'b0, ram_raddr}, 32'h4);
    idle(32'h0);
    chk("r1_hrdata", HRDATA, 32'hDEADBEEF);
    chk("r1_ready",  {30'b0, HREADYOUT, HRESP}, 32'h2);
    chk("r1_we",     {28'b0, ram_we}, 32'h0);
    cyc(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h10, 32'h0);
    idle(32'h0);
    chk("r1b_hrdata", HRDATA, 32'hDEADBEEF);

    // byte write over a known word
    cyc(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h10, 32'h0);
    cyc(1'b1, T_NONSEQ, 1'b1, 3'd0, 32'h13, 32'h11223344);
    cyc(1'b0, T_IDLE,   1'b0, 3'd2, 32'h0,  32'hAA000000);
    chk("b_we",    {28'b0, ram_we}, 32'h8);
    chk("b_waddr", {24'b0, ram_waddr}, 32'h4);
    cyc(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h10, 32'h0);
    idle(32'h0);
    chk("b_hrdata", HRDATA, 32'hAA223344);

    // half write, read of same word on the next cycle goes through the bypass
    cyc(1'b1, T_NONSEQ, 1'b1, 3'd1, 32'h22, 32'h0);
    cyc(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h20, 32'h55660000);
    chk("h_we", {28'b0, ram_we}, 32'hC);
    idle(32'h0);
    chk("h_hrdata", HRDATA, 32'h55660000);

    // back-to-back burst writes and reads
    cyc(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h30, 32'h0);
    cyc(1'b1, T_SEQ,    1'b1, 3'd2, 32'h34, 32'hA1A2A3A4);
    chk("bb_waddr0", {24'b0, ram_waddr}, 32'hC);
    idle(32'hB1B2B3B4);
    chk("bb_waddr1", {24'b0, ram_waddr}, 32'hD);
    chk("bb_we1",    {28'b0, ram_we}, 32'hF);
    cyc(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h30, 32'h0);
    cyc(1'b1, T_SEQ,    1'b0, 3'd2, 32'h34, 32'h0);
    chk("bb_rd0", HRDATA, 32'hA1A2A3A4);
    idle(32'h0);
    chk("bb_rd1", HRDATA, 32'hB1B2B3B4);

    // out-of-range read: two-cycle ERROR
    cyc(1'b1, T_NONSEQ, 1'b0, 3'd2, DEPTH * 4, 32'h0);
    idle(32'h0);
    chk("oor_err1", {30'b0, HREADYOUT, HRESP}, 32'h1);
    chk("oor_we1",  {28'b0, ram_we}, 32'h0);
    chk("oor_rd1",  HRDATA, 32'h0);
    idle(32'h0);
    chk("oor_err2", {30'b0, HREADYOUT, HRESP}, 32'h3);
    idle(32'h0);
    chk("oor_ok",   {30'b0, HREADYOUT, HRESP}, 32'h2);

    // misaligned half write, then HSIZE=3 write issued during ERR2
    cyc(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h00, 32'h0);
    idle(32'h12345678);
    cyc(1'b1, T_NONSEQ, 1'b1, 3'd1, 32'h01, 32'h0);
    idle(32'hFFFFFFFF);
    chk("mis_err1", {30'b0, HREADYOUT, HRESP}, 32'h1);
    chk("mis_we1",  {28'b0, ram_we}, 32'h0);
    cyc(1'b1, T_NONSEQ, 1'b1, 3'd3, 32'h00, 32'h0);
    chk("mis_err2", {30'b0, HREADYOUT, HRESP}, 32'h3);
    idle(32'hFFFFFFFF);
    chk("sz3_err1", {30'b0, HREADYOUT, HRESP}, 32'h1);
    chk("sz3_we1",  {28'b0, ram_we}, 32'h0);
    idle(32'h0);
    chk("sz3_err2", {30'b0, HREADYOUT, HRESP}, 32'h3);
    chk("sz3_we2",  {28'b0, ram_we}, 32'h0);
    cyc(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h00, 32'h0);
    chk("sz3_ok",   {30'b0, HREADYOUT, HRESP}, 32'h2);
    idle(32'h0);
    chk("err_readback", HRDATA, 32'h12345678);

    // asynchronous reset while in ERR1
    cyc(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h0000_1000, 32'h0);
    idle(32'h0);
    chk("rstm_err1", {30'b0, HREADYOUT, HRESP}, 32'h1);
    HRESETn = 1'b0;
    #1;
    chk("rstm_clear", {30'b0, HREADYOUT, HRESP}, 32'h2);
    @(negedge HCLK);
    HRESETn = 1'b1;
    cyc(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h10, 32'h0);
    idle(32'h0);
    chk("rstm_rd",   HRDATA, 32'hAA223344);
    chk("rstm_resp", {30'b0, HREADYOUT, HRESP}, 32'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
